// File: rtl/mod_updown_counter.sv
// Parametrised up/down counter with modulus, load, wrap/saturate bound modes and wrap/overflow status.
// Registered count/wrap/ovf (1-cycle latency); tc is combinational from count and up.
module mod_updown_counter #(
  parameter int              WIDTH   = 8,
  parameter longint unsigned MODULUS = 64'd1 << WIDTH,
  parameter longint unsigned RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 64'd1);
  localparam logic [WIDTH-1:0] RSTV = WIDTH'(RST_VAL);

  logic [WIDTH-1:0] count_nxt;
  logic             wrap_nxt;
  logic             ovf_nxt;
  logic             at_bound;

  // The bound in the current direction doubles as the terminal-count output.
  assign at_bound = up ? (count == MAXV) : (count == '0);
  assign tc       = at_bound;

  always_comb begin
    count_nxt = count;
    wrap_nxt  = 1'b0;
    ovf_nxt   = ovf & ~clr_ovf;
    if (load) begin
      count_nxt = (load_val > MAXV) ? MAXV : load_val;
    end else if (en) begin
      if (at_bound) begin
        ovf_nxt = 1'b1;
        if (!sat) begin
          // Explicit wrap target so a short modulus never depends on 2**WIDTH rollover.
          count_nxt = up ? '0 : MAXV;
          wrap_nxt  = 1'b1;
        end
      end else begin
        count_nxt = up ? count + WIDTH'(1) : count - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= RSTV;
      wrap  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      count <= count_nxt;
      wrap  <= wrap_nxt;
      ovf   <= ovf_nxt;
    end
  end

endmodule
